// File: rtl/osc_pkg.sv
// Shared types and helpers for the oscilloscope display path.
package osc_pkg;
  localparam int SAMPLE_W  = 12;
  localparam int BUF_DEPTH = 512;
  localparam int COORD_W   = 11;
  localparam int RGB_W     = 12;
  localparam int IDX_W     = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_VBLANK, COPY} render_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
  } vga_timing_t;

  // Larger samples map to higher rows on screen (smaller row number).
  function automatic logic [COORD_W-1:0] sample_to_row(input logic [SAMPLE_W-1:0] s,
                                                       input int win_y, input int shift);
    logic [COORD_W-1:0] base;
    base = COORD_W'(win_y + BUF_DEPTH - 1);
    return base - COORD_W'(s >> shift);
  endfunction
endpackage

// File: rtl/vga_delay.sv
// N-cycle register delay for the VGA timing bundle.
module vga_delay
  import osc_pkg::*;
#(
  parameter int N = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  vga_timing_t din,
  output vga_timing_t dout
);
  vga_timing_t pipe [N];

  // Shift the timing bundle one stage per clock, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[N-1];
endmodule

// File: rtl/waveform_render.sv
// Snapshots the trigger buffer into a screen-row table during vblank and
// overlays it as a continuous trace onto the passing VGA stream.
module waveform_render
  import osc_pkg::*;
#(
  parameter int               WIN_X        = 256,
  parameter int               WIN_Y        = 128,
  parameter int               SAMPLE_SHIFT = 3,
  parameter logic [RGB_W-1:0] TRACE_RGB    = 12'h0F0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic [SAMPLE_W-1:0] trig_buffer [0:BUF_DEPTH-1],
  input  logic [COORD_W-1:0]  hcount_in,
  input  logic [COORD_W-1:0]  vcount_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                hblnk_in,
  input  logic                vblnk_in,
  input  logic [RGB_W-1:0]    rgb_in,
  output logic [COORD_W-1:0]  hcount_out,
  output logic [COORD_W-1:0]  vcount_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                hblnk_out,
  output logic                vblnk_out,
  output logic [RGB_W-1:0]    rgb_out,
  output logic                busy
);
  localparam logic [COORD_W-1:0] BOTTOM_ROW = COORD_W'(WIN_Y + BUF_DEPTH - 1);
  localparam logic [COORD_W-1:0] X_LO = COORD_W'(WIN_X);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(WIN_X + BUF_DEPTH - 1);
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(WIN_Y);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(WIN_Y + BUF_DEPTH - 1);

  render_state_t      state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               pending, pending_n;
  logic               read_d, vblnk_d;
  logic               rise, vblank_start;
  logic [COORD_W-1:0] ybuf [BUF_DEPTH];

  assign rise         = read & ~read_d;
  assign vblank_start = vblnk_in & ~vblnk_d;
  assign busy         = (state != IDLE);

  // Capture FSM registers and edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      pending <= 1'b0;
      read_d  <= 1'b0;
      vblnk_d <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      pending <= pending_n;
      read_d  <= read;
      vblnk_d <= vblnk_in;
    end
  end

  // Next-state: one capture scheduled per rise, one extra remembered during COPY.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pending_n = pending;
    case (state)
      IDLE:        if (rise) state_n = WAIT_VBLANK;
      WAIT_VBLANK: if (vblank_start) begin
        state_n = COPY;
        idx_n   = '0;
      end
      COPY: begin
        idx_n = idx + IDX_W'(1);
        if (rise) pending_n = 1'b1;
        if (idx == IDX_W'(BUF_DEPTH - 1)) begin
          // A rise on the final copy cycle still counts as pending.
          if (pending || rise) begin
            state_n   = WAIT_VBLANK;
            pending_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Screen-row table: flat bottom trace on reset, one entry per COPY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) ybuf[i] <= BOTTOM_ROW;
    end else if (state == COPY) begin
      ybuf[idx] <= sample_to_row(trig_buffer[idx], WIN_Y, SAMPLE_SHIFT);
    end
  end

  // Stage 1 lookup.
  logic [IDX_W-1:0]   col, col_prev;
  logic               in_win, in_win_q;
  logic [COORD_W-1:0] y_cur_q, y_prev_q, lo, hi;
  logic [RGB_W-1:0]   rgb_q;
  vga_timing_t        tim_in, tim_s1, tim_s2;

  assign in_win   = (hcount_in >= X_LO) && (hcount_in <= X_HI) &&
                    (vcount_in >= Y_LO) && (vcount_in <= Y_HI);
  assign col      = IDX_W'(hcount_in - X_LO);
  assign col_prev = (col == '0) ? '0 : col - IDX_W'(1);

  // Register window hit, the two neighbouring trace rows and background colour.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_win_q <= 1'b0;
      y_cur_q  <= '0;
      y_prev_q <= '0;
      rgb_q    <= '0;
    end else begin
      in_win_q <= in_win;
      y_cur_q  <= ybuf[col];
      y_prev_q <= ybuf[col_prev];
      rgb_q    <= rgb_in;
    end
  end

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  vga_delay #(.N(1)) u_dly_s1 (.clk(clk), .rst(rst), .din(tim_in), .dout(tim_s1));
  vga_delay #(.N(1)) u_dly_s2 (.clk(clk), .rst(rst), .din(tim_s1), .dout(tim_s2));

  // Stage 2: fill the vertical span between neighbouring rows so steep edges join.
  assign lo = (y_cur_q < y_prev_q) ? y_cur_q : y_prev_q;
  assign hi = (y_cur_q < y_prev_q) ? y_prev_q : y_cur_q;

  // Stage 2 colour select.
  always_ff @(posedge clk) begin
    if (rst) rgb_out <= '0;
    else if (in_win_q && (tim_s1.vcount >= lo) && (tim_s1.vcount <= hi)) rgb_out <= TRACE_RGB;
    else rgb_out <= rgb_q;
  end

  assign hcount_out = tim_s2.hcount;
  assign vcount_out = tim_s2.vcount;
  assign hsync_out  = tim_s2.hsync;
  assign vsync_out  = tim_s2.vsync;
  assign hblnk_out  = tim_s2.hblnk;
  assign vblnk_out  = tim_s2.vblnk;
endmodule

// File: tb/tb_waveform_render.sv
// Randomised bench for waveform_render against a screen-row model.
module tb_waveform_render;
  logic        clk = 0, rst = 1, read = 0;
  logic [11:0] tbuf [0:511];
  logic [10:0] hc = 0, vc = 0;
  logic        hs = 0, vs = 0, hb = 0, vb = 0;
  logic [11:0] rgb = 0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, busy;
  logic [11:0] rgb_out;

  int n_cmp = 0, n_err = 0;
  bit chk_rgb = 0;
  int mbuf [512];
  int since_rst = 0;

  typedef struct packed {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
  } smp_t;
  smp_t cur, prev;
  logic mon_rst;

  waveform_render dut (
    .clk(clk), .rst(rst), .read(read), .trig_buffer(tbuf),
    .hcount_in(hc), .vcount_in(vc), .hsync_in(hs), .vsync_in(vs),
    .hblnk_in(hb), .vblnk_in(vb), .rgb_in(rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected pixel colour: lit when v lies between this column's row and its left neighbour's.
  function automatic logic [11:0] exp_rgb(int h, int v, logic [11:0] bg);
    int c, yc, yp;
    if (h < 256 || h > 767 || v < 128 || v > 639) return bg;
    c  = h - 256;
    yc = mbuf[c];
    yp = (c == 0) ? mbuf[0] : mbuf[c-1];
    if ((v - yc) * (v - yp) <= 0) return 12'h0F0;
    return bg;
  endfunction

  // Per-cycle monitor: outputs after each edge reflect the inputs seen one edge earlier.
  always @(posedge clk) begin
    cur = '{hc, vc, hs, vs, hb, vb, rgb};
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      since_rst = 0;
      n_cmp++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, busy} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got h=%0d v=%0d rgb=%h busy=%b, want all 0",
                 hcount_out, vcount_out, rgb_out, busy);
      end
    end else begin
      since_rst++;
      if (since_rst >= 2) begin
        n_cmp++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
            {prev.h, prev.v, prev.hs, prev.vs, prev.hb, prev.vb}) begin
          n_err++;
          $display("FAIL timing_delay: got h=%0d v=%0d s=%b%b%b%b, want h=%0d v=%0d s=%b%b%b%b",
                   hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                   prev.h, prev.v, prev.hs, prev.vs, prev.hb, prev.vb);
        end
        if (chk_rgb) begin
          n_cmp++;
          if (rgb_out !== exp_rgb(int'(prev.h), int'(prev.v), prev.rgb)) begin
            n_err++;
            $display("FAIL pixel_rgb at (%0d,%0d): got %h, want %h", prev.h, prev.v,
                     rgb_out, exp_rgb(int'(prev.h), int'(prev.v), prev.rgb));
          end
        end
      end
    end
    prev = cur;
  end

  task automatic rand_pix();
    int c;
    if ($urandom_range(0, 1) == 1) begin
      c  = int'($urandom_range(0, 511));
      hc = 11'(256 + c);
      vc = 11'(mbuf[c] + int'($urandom_range(0, 6)) - 3);
    end else begin
      hc = 11'($urandom_range(0, 1100));
      vc = 11'($urandom_range(0, 800));
    end
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    hb  = 1'($urandom);
    rgb = 12'($urandom);
  endtask

  task automatic steps(int n);
    repeat (n) begin
      @(negedge clk);
      rand_pix();
    end
  endtask

  task automatic load_model();
    for (int i = 0; i < 512; i++) mbuf[i] = 639 - int'(tbuf[i]) / 8;
  endtask

  // Raise vblnk and count cycles busy stays high from the blanking edge.
  task automatic wait_copy(output int cnt);
    @(negedge clk);
    rand_pix();
    vb  = 1;
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rand_pix();
      if (busy) cnt++;
      else break;
    end
    vb = 0;
  endtask

  task automatic settle();
    steps(2);
    chk_rgb = 1;
  endtask

  task automatic pulse_read();
    @(negedge clk);
    read = 1;
    @(negedge clk);
    read = 0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_read: got %b, want 1", busy);
    end
  endtask

  // Capture the current tbuf, checking the copy lasts exactly 512 cycles.
  task automatic capture(string name);
    int cnt;
    chk_rgb = 0;
    pulse_read();
    wait_copy(cnt);
    n_cmp++;
    if (cnt != 512) begin
      n_err++;
      $display("FAIL %s_copy_cycles: got %0d, want 512", name, cnt);
    end
    load_model();
    settle();
  endtask

  task automatic check_pix(string name, int h, int v, bit lit);
    logic [11:0] bg, want;
    bg = 12'($urandom) & 12'hF0F;
    @(negedge clk);
    hc = 11'(h); vc = 11'(v); rgb = bg;
    @(negedge clk);
    @(negedge clk);
    want = lit ? 12'h0F0 : bg;
    n_cmp++;
    if (rgb_out !== want) begin
      n_err++;
      $display("FAIL %s (%0d,%0d): got %h, want %h", name, h, v, rgb_out, want);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    steps(3);
    n_cmp++;
    if (busy !== 1'b0 || rgb_out !== 12'h0 || hcount_out !== 11'h0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b rgb=%h h=%0d, want 0 0 0", busy, rgb_out, hcount_out);
    end
    for (int i = 0; i < 512; i++) mbuf[i] = 639;
    @(negedge clk);
    rst = 0;
    chk_rgb = 1;
  endtask

  task automatic test_flat();
    int ph[6] = '{256, 767, 255, 768, 300, 512};
    int pv[6] = '{639, 639, 639, 639, 638, 128};
    bit pl[6] = '{1, 1, 0, 0, 0, 0};
    steps(400);
    for (int i = 0; i < 6; i++) check_pix("flat", ph[i], pv[i], pl[i]);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flat_busy: got %b, want 0", busy);
    end
  endtask

  task automatic test_mid();
    int ph[6] = '{256, 767, 512, 512, 255, 768};
    int pv[6] = '{383, 383, 383, 639, 383, 383};
    bit pl[6] = '{1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 512; i++) tbuf[i] = 12'h800;
    capture("mid");
    steps(400);
    for (int i = 0; i < 6; i++) check_pix("mid", ph[i], pv[i], pl[i]);
  endtask

  task automatic test_step();
    int ph[9] = '{512, 512, 512, 512, 512, 511, 511, 513, 513};
    int pv[9] = '{127, 128, 300, 639, 640, 639, 638, 128, 129};
    bit pl[9] = '{0, 1, 1, 1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 512; i++) tbuf[i] = (i < 256) ? 12'h000 : 12'hFFF;
    capture("step");
    steps(400);
    for (int i = 0; i < 9; i++) check_pix("step", ph[i], pv[i], pl[i]);
  endtask

  task automatic test_back_to_back();
    int rises, cnt;
    bit pb, all_busy;
    // Holding read high yields one capture only.
    for (int i = 0; i < 512; i++) tbuf[i] = 12'($urandom);
    chk_rgb = 0;
    rises = 0; pb = 0;
    @(negedge clk);
    read = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rand_pix();
      if (i == 20) vb = 1;
      if (i == 700) vb = 0;
      if (busy && !pb) rises++;
      pb = busy;
    end
    n_cmp++;
    if (rises != 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL held_read: got %0d captures busy=%b, want 1 capture busy=0", rises, busy);
    end
    read = 0;
    load_model();
    settle();
    steps(200);
    // Second rise during COPY queues exactly one more capture.
    for (int i = 0; i < 512; i++) tbuf[i] = 12'($urandom);
    chk_rgb = 0;
    pulse_read();
    @(negedge clk);
    vb = 1;
    steps(50);
    @(negedge clk);
    read = 1;
    @(negedge clk);
    read = 0;
    all_busy = 1;
    for (int i = 0; i < 470; i++) begin
      @(negedge clk);
      rand_pix();
      if (!busy) all_busy = 0;
    end
    vb = 0;
    for (int i = 0; i < 512; i++) tbuf[i] = 12'($urandom);
    steps(5);
    n_cmp++;
    if (!all_busy || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pending_busy: got all_busy=%b busy=%b, want 1 1", all_busy, busy);
    end
    wait_copy(cnt);
    n_cmp++;
    if (cnt != 512) begin
      n_err++;
      $display("FAIL pending_copy_cycles: got %0d, want 512", cnt);
    end
    load_model();
    settle();
    steps(400);
  endtask

  task automatic test_reset_mid_copy();
    for (int i = 0; i < 512; i++) tbuf[i] = 12'($urandom);
    chk_rgb = 0;
    pulse_read();
    @(negedge clk);
    vb = 1;
    steps(101);
    rst = 1;
    steps(1);
    n_cmp++;
    if (busy !== 1'b0 || rgb_out !== 12'h0 || vcount_out !== 11'h0) begin
      n_err++;
      $display("FAIL reset_mid_copy: got busy=%b rgb=%h v=%0d, want 0 0 0", busy, rgb_out, vcount_out);
    end
    vb = 0;
    steps(2);
    for (int i = 0; i < 512; i++) mbuf[i] = 639;
    rst = 0;
    chk_rgb = 1;
    steps(300);
    check_pix("after_rst", 300, 639, 1);
    check_pix("after_rst", 300, 500, 0);
  endtask

  task automatic test_timing();
    repeat (1600) begin
      @(negedge clk);
      rand_pix();
      vb = 1'($urandom);
    end
    vb = 0;
    steps(3);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL timing_busy: got %b, want 0", busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) tbuf[i] = 12'h0;
    test_reset();
    test_flat();
    test_mid();
    test_step();
    test_back_to_back();
    test_reset_mid_copy();
    test_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
